// File: rtl/jt12_rst_pkg.sv
// Shared types and elaboration helpers for the JT12 reset sequencer.
package jt12_rst_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HOLD,
    ST_REL,
    ST_DONE
  } state_t;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MAX_NCH         = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

  function automatic bit params_legal(input int unsigned stages, input int unsigned nch,
                                      input int unsigned hold, input int unsigned gap);
    return (stages >= MIN_SYNC_STAGES) && (nch >= 1) && (nch <= MAX_NCH) &&
           (hold >= 1) && (gap >= 1);
  endfunction

endpackage

// File: rtl/jt12_rst_seq_sync.sv
// Reset synchroniser: asynchronous assertion, deassertion shifted through STAGES falling-edge flops.
module jt12_rst_sync
  import jt12_rst_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_ok
);

  logic [STAGES-1:0] chain;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign sync_ok = chain[STAGES-1];

endmodule

// File: rtl/jt12_rst_seq.sv
// Sequenced reset generator: synchronised release, minimum hold, then NCH domains released in order.
// Optional soft reset request input sw_rst enabled by JT12_RST_SWREQ_EN.
module jt12_rst_seq
  import jt12_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NCH         = 3,
  parameter int unsigned HOLD        = 16,
  parameter int unsigned GAP         = 4
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef JT12_RST_SWREQ_EN
  input  logic           sw_rst,
`endif
  output logic [NCH-1:0] rst_out_n,
  output logic           done
);

  localparam int unsigned CW = clog2((HOLD > GAP) ? HOLD : GAP) + 1;
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_M1  = CW'(GAP - 1);

  if (!params_legal(SYNC_STAGES, NCH, HOLD, GAP)) begin : g_bad_params
    $error("jt12_rst_seq: illegal parameter set");
  end

  logic           sync_ok;
  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [NCH-1:0] rst_nxt, rst_shift;
  logic           done_nxt;
  logic           release_ch;

  jt12_rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_ok (sync_ok)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SYNC;
      cnt       <= '0;
      rst_out_n <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_out_n <= rst_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rst_nxt    = rst_out_n;
    done_nxt   = done;
    release_ch = 1'b0;
    // Shifting a 1 in keeps the output a thermometer code without an index register.
    rst_shift  = (rst_out_n << 1) | NCH'(1);

    case (state)
      ST_SYNC: begin
        // The edge leaving SYNC is the first of the HOLD edges.
        if (sync_ok) begin
          if (HOLD == 1) begin
            release_ch = 1'b1;
          end else begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_M1)   release_ch = 1'b1;
        else if (cnt != '1)   cnt_nxt = cnt + CW'(1);
      end
      ST_REL: begin
        if (cnt == GAP_M1)    release_ch = 1'b1;
        else if (cnt != '1)   cnt_nxt = cnt + CW'(1);
      end
      default: ;
    endcase

    if (release_ch) begin
      rst_nxt = rst_shift;
      cnt_nxt = '0;
      if (rst_shift[NCH-1]) begin
        state_nxt = ST_DONE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = ST_REL;
      end
    end

`ifdef JT12_RST_SWREQ_EN
    // Soft reset leaves the sync chain alone; before sync_ok it simply keeps waiting in SYNC.
    if (sw_rst) begin
      rst_nxt   = '0;
      done_nxt  = 1'b0;
      cnt_nxt   = '0;
      state_nxt = (state == ST_SYNC && !sync_ok) ? ST_SYNC : ST_HOLD;
    end
`endif
  end

endmodule

// File: tb/tb_jt12_rst_seq.sv
// Self-checking bench for jt12_rst_seq (default build and JT12_RST_SWREQ_EN build).
module tb_jt12_rst_seq;

  localparam int S = 2;
  localparam int H = 16;
  localparam int G = 4;
  localparam int N = 3;
  localparam int B_LAT = 4;  // SYNC_STAGES=3, HOLD=1, NCH=1 instance

  logic clk = 1'b0;
  logic rst_n = 1'b1;
`ifdef JT12_RST_SWREQ_EN
  logic sw_rst = 1'b0;
`endif
  logic [N-1:0] rst_out_n;
  logic         done;
  logic [0:0]   rst_out_n_b;
  logic         done_b;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [N-1:0] rst;
    logic         done;
    logic         rst_b;
    logic         done_b;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jt12_rst_seq #(.SYNC_STAGES(S), .NCH(N), .HOLD(H), .GAP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef JT12_RST_SWREQ_EN
    .sw_rst    (sw_rst),
`endif
    .rst_out_n (rst_out_n),
    .done      (done)
  );

  jt12_rst_seq #(.SYNC_STAGES(3), .NCH(1), .HOLD(1), .GAP(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef JT12_RST_SWREQ_EN
    .sw_rst    (1'b0),
`endif
    .rst_out_n (rst_out_n_b),
    .done      (done_b)
  );

  function automatic int released(input int e, input int thr);
    int k;
    if (e < thr) return 0;
    k = 1 + (e - thr) / G;
    return (k > N) ? N : k;
  endfunction

  function automatic exp_t model(input int e, input int thr, input bit b_seq);
    exp_t x;
    int k;
    k = released(e, thr);
    x.rst = '0;
    for (int i = 0; i < N; i++) if (i < k) x.rst[i] = 1'b1;
    x.done   = (k == N);
    x.rst_b  = b_seq ? (e >= B_LAT) : 1'b1;
    x.done_b = x.rst_b;
    return x;
  endfunction

  always @(negedge clk) begin
    #2;
    assert ((((rst_out_n + 3'd1) & rst_out_n) == 3'd0) && (done == rst_out_n[N-1]) &&
            (done_b == rst_out_n_b[0]) && (dut.cnt <= 5'd16))
    else begin
      miscompares++;
      $display("FAIL invariant t=%0t rst_out_n=%b done=%b cnt=%0d", $time, rst_out_n, done, dut.cnt);
    end
  end

  task automatic test_reset();
    logic [5:0] obs;
    #2 rst_n = 1'b0;
    #1;
    obs = {rst_out_n, done, rst_out_n_b, done_b};
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_async got %b want %b", obs, 6'b0);
    end
    repeat (3) @(negedge clk);
    #1;
    obs = {rst_out_n, done, rst_out_n_b, done_b};
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_held got %b want %b", obs, 6'b0);
    end
  endtask

  task automatic test_release();
    exp_t x;
    @(posedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      sb.push_back(model(e, S + H, 1'b1));
      @(negedge clk); #1;
      x = sb.pop_front();
      vectors++;
      if ({rst_out_n, done, rst_out_n_b, done_b} !== x) begin
        miscompares++;
        $display("FAIL release edge %0d got %b want %b", e, {rst_out_n, done, rst_out_n_b, done_b}, x);
      end
    end
  endtask

  task automatic test_async_after_done();
    exp_t x;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rst_out_n, done, rst_out_n_b, done_b} !== 6'b0) begin
      miscompares++;
      $display("FAIL async_pulse got %b want %b", {rst_out_n, done, rst_out_n_b, done_b}, 6'b0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      sb.push_back(model(e, S + H, 1'b1));
      @(negedge clk); #1;
      x = sb.pop_front();
      vectors++;
      if ({rst_out_n, done, rst_out_n_b, done_b} !== x) begin
        miscompares++;
        $display("FAIL after_pulse edge %0d got %b want %b", e, {rst_out_n, done, rst_out_n_b, done_b}, x);
      end
    end
  endtask

  task automatic test_mid_sequence();
    exp_t x;
    @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      sb.push_back(model(e, S + H, 1'b1));
      @(negedge clk); #1;
      x = sb.pop_front();
      vectors++;
      if ({rst_out_n, done, rst_out_n_b, done_b} !== x) begin
        miscompares++;
        $display("FAIL mid_pre edge %0d got %b want %b", e, {rst_out_n, done, rst_out_n_b, done_b}, x);
      end
    end
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rst_out_n !== 3'b000 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear got %b/%b want 000/0", rst_out_n, done);
    end
    @(posedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      sb.push_back(model(e, S + H, 1'b1));
      @(negedge clk); #1;
      x = sb.pop_front();
      vectors++;
      if ({rst_out_n, done, rst_out_n_b, done_b} !== x) begin
        miscompares++;
        $display("FAIL mid_restart edge %0d got %b want %b", e, {rst_out_n, done, rst_out_n_b, done_b}, x);
      end
    end
  endtask

`ifdef JT12_RST_SWREQ_EN
  task automatic test_sw_rst();
    exp_t x;
    @(posedge clk);
    sw_rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      sb.push_back(model(0, 1000, 1'b0));
      @(negedge clk); #1;
      x = sb.pop_front();
      vectors++;
      if ({rst_out_n, done, rst_out_n_b, done_b} !== x) begin
        miscompares++;
        $display("FAIL sw_high edge %0d got %b want %b", e, {rst_out_n, done, rst_out_n_b, done_b}, x);
      end
    end
    sw_rst = 1'b0;
    for (int e = 1; e <= 28; e++) begin
      sb.push_back(model(e, H, 1'b0));
      @(negedge clk); #1;
      x = sb.pop_front();
      vectors++;
      if ({rst_out_n, done, rst_out_n_b, done_b} !== x) begin
        miscompares++;
        $display("FAIL sw_release edge %0d got %b want %b", e, {rst_out_n, done, rst_out_n_b, done_b}, x);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
`ifdef JT12_RST_SWREQ_EN
      sw_rst = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rst_out_n, done, rst_out_n_b, done_b} !== 6'b0) begin
          miscompares++;
          $display("FAIL random_clear iter %0d got %b want %b", i, {rst_out_n, done, rst_out_n_b, done_b}, 6'b0);
        end
        #($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
`ifdef JT12_RST_SWREQ_EN
    sw_rst = 1'b0;
`endif
  endtask

  task automatic test_back_to_back();
    exp_t x;
    @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      sb.push_back(model(e, S + H, 1'b1));
      @(negedge clk); #1;
      x = sb.pop_front();
      vectors++;
      if ({rst_out_n, done, rst_out_n_b, done_b} !== x) begin
        miscompares++;
        $display("FAIL back_to_back edge %0d got %b want %b", e, {rst_out_n, done, rst_out_n_b, done_b}, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_async_after_done();
    test_mid_sequence();
`ifdef JT12_RST_SWREQ_EN
    test_sw_rst();
`endif
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
